nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder: adds a + b + cin one 4-bit nibble per clock.
//  A registered carry links successive nibbles through one 4-bit ripple slice.
//  Sits upstream of result consumers; valid/ready on both sides.
//  Trades latency for area versus a flat WIDTH-bit ripple chain.
// PARAMETERS
//  WIDTH    16   operand/sum width; must be a multiple of 4 and >= 4 (elaboration-time check)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand set a/b/cin valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  a          in   WIDTH  operand A, unsigned
//  b          in   WIDTH  operand B, unsigned
//  cin        in   1      carry-in to nibble 0
//  out_valid  out  1      sum/cout valid (DONE state)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  registered result a+b+cin mod 2^WIDTH
//  cout       out  1      carry out of MSB nibble
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): state=IDLE; in_ready=1 after reset; out_valid=0, sum=0, cout=0.
//    Operand regs, carry reg and nibble counter are cleared.
//  - FSM states IDLE, RUN, DONE:
//    IDLE: in_ready=1. On in_valid&&in_ready, latch a, b; carry<=cin; idx<=0; go to RUN.
//    RUN: in_ready=0. Each cycle: {c,s} = a[idx]+b[idx]+carry (4-bit nibble slice).
//         Write s to sum[4*idx+:4]; carry<=c; idx++.
//         On idx==NNIB-1, cout<=c and go to DONE. NNIB = WIDTH/4.
//    DONE: out_valid=1; sum/cout held stable. On out_ready go to IDLE (out_valid=0 next cycle).
//  - Latency: out_valid rises exactly NNIB edges after the accepting edge (WIDTH=16 -> 4).
//  - Throughput: one result per NNIB+2 cycles minimum. No overlap: in_ready stays 0 in DONE.
//  - in_valid in RUN/DONE is ignored; a/b/cin changes after acceptance have no effect.
//  - out_ready in IDLE/RUN is ignored. out_ready held low in DONE stalls indefinitely.
//  - sum is cleared to 0 on acceptance, so partially written nibbles never show stale data.
//  - Reset mid-RUN or mid-DONE aborts: no out_valid pulse; return to reset values.
//  - Wrap-around: result is modulo 2^WIDTH; the carry-out appears only on cout.
// CONFIGURATION
//  OVERFLOW_FLAG_EN defined: extra output port ovf (out, 1).
//    ovf = signed two's-complement overflow = carry into MSB ^ carry out of MSB.
//    ovf is captured in the last RUN cycle, valid with out_valid, and reset to 0.
//  Undefined: port ovf and its logic are absent; all other behaviour is identical.
// STRUCTURE
//  Shared package adder_pkg:
//    - NIBBLE_W=4 constant
//    - state typedef (IDLE, RUN, DONE)
//    - nibble-count helper function (WIDTH/NIBBLE_W)
//  Sub-module add4_slice: combinational 4-bit adder, (a4, b4, ci) -> (s4, co).
//    Built from four 1-bit full-adder cells; instantiated once.
// TESTING
//  1. 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1; out_valid 4 edges after acceptance.
//  2. 0x1234+0x4321, cin=1 -> sum=0x5556, cout=0; in_ready=0 from acceptance until the return to IDLE.
//  3. Backpressure: out_ready=0 for 5 cycles in DONE -> sum/cout stable, in_ready=0.
//     Then out_ready=1 -> IDLE and in_ready=1 on the next cycle.
//  4. rst=1 after 2 RUN cycles -> next cycle out_valid=0, sum=0, in_ready=1; no result emitted.
//  5. Drive a new in_valid with different operands while in RUN -> ignored; first result unchanged.
//  6. OVERFLOW_FLAG_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
//     0xFFFF+0x0001 -> ovf=0.
//     Also 1000 random vectors checked against a+b+cin (both builds).

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the nibble width, FSM state type and nibble-count helper.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nib_count(input int w);
        return w / NIBBLE_W;
    endfunction

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple slice built from 1-bit full-adder cells.
// One instance is reused every cycle by the nibble-serial adder.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

module add4_slice
    import adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a4,
    input  logic [NIBBLE_W-1:0] b4,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s4,
    output logic                co
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        fa_cell u_fa (
            .x  (a4[i]),
            .y  (b4[i]),
            .ci (c[i]),
            .s  (s4[i]),
            .co (c[i+1])
        );
    end

    assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one nibble of a+b+cin per clock through a single slice.
// Define OVERFLOW_FLAG_EN to add the signed-overflow output ovf.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef OVERFLOW_FLAG_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int NNIB = nib_count(WIDTH);
    localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NNIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t            state;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic              carry;
    logic [IDXW-1:0]   idx;

    logic [NIBBLE_W-1:0] s4;
    logic                co;
    logic                c_msb;

    // Operands shift right each RUN cycle, so the slice always sees nibble 0.
    add4_slice u_slice (
        .a4 (a_q[NIBBLE_W-1:0]),
        .b4 (b_q[NIBBLE_W-1:0]),
        .ci (carry),
        .s4 (s4),
        .co (co)
    );

    // Carry into the MSB recovered from the sum bit: s = a ^ b ^ c.
    assign c_msb = a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1] ^ s4[NIBBLE_W-1];

`ifdef OVERFLOW_FLAG_EN
    // Signed overflow is captured alongside cout on the final nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) ovf <= 1'b0;
                RUN:  if (idx == LAST) ovf <= c_msb ^ co;
                default: ;
            endcase
        end
    end
`else
    logic unused_c_msb;
    assign unused_c_msb = c_msb;
`endif

    // Control FSM with registered handshake outputs and nibble write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        carry    <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        cout     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum[int'(idx) * NIBBLE_W +: NIBBLE_W] <= s4;
                    carry <= co;
                    a_q   <= a_q >> NIBBLE_W;
                    b_q   <= b_q >> NIBBLE_W;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        cout      <= co;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
// Reference model works on whole-word arithmetic and a cycle count.
module tb_nibble_serial_adder;

    localparam int W    = 16;
    localparam int NNIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef OVERFLOW_FLAG_EN
        .cout      (cout),
        .ovf       (ovf)
`else
        .cout      (cout)
`endif
    );

    task automatic check(input string name, input logic [W:0] act,
                         input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 busy, 2 holding result
    int           m_phase = 0;
    int           m_k     = 0;
    bit           m_live  = 0;
    logic [W:0]   m_full  = '0;
    logic [W-1:0] m_sum   = '0;
    logic         m_cout  = 1'b0;
    logic         m_ovf   = 1'b0;
    logic         m_sa, m_sb;
    int           m_results = 0;
    int           dut_results = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_live  = 1;
            m_phase = 0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_ovf   = 1'b0;
        end else if (m_live) begin
            case (m_phase)
                0: if (in_valid) begin
                    m_full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                    m_sa    = a[W-1];
                    m_sb    = b[W-1];
                    m_k     = 0;
                    m_sum   = '0;
                    m_cout  = 1'b0;
                    m_ovf   = 1'b0;
                    m_phase = 1;
                end
                1: begin
                    m_k++;
                    m_sum = m_full[W-1:0] & ~({W{1'b1}} << (4 * m_k));
                    if (m_k == NNIB) begin
                        m_cout  = m_full[W];
                        m_ovf   = (m_sa == m_sb) && (m_full[W-1] != m_sa);
                        m_phase = 2;
                    end
                end
                default: if (out_ready) begin
                    m_phase = 0;
                    m_results++;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready) dut_results++;
    end

    // Cycle-by-cycle comparison of DUT against the model.
    always @(negedge clk) begin
        if (m_live && !rst) begin
            check("in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, m_phase == 0});
            check("out_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, m_phase == 2});
            check("sum", {1'b0, sum}, {1'b0, m_sum});
            check("cout", {{W{1'b0}}, cout}, {{W{1'b0}}, m_cout});
`ifdef OVERFLOW_FLAG_EN
            if (m_phase == 2)
                check("ovf", {{W{1'b0}}, ovf}, {{W{1'b0}}, m_ovf});
`endif
        end
    end

    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic vc);
        @(negedge clk);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) begin
            checks++;
            failures++;
            $display("FAIL timeout: out_valid never rose");
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int           lat;
    logic [W:0]   exp_full;
    logic [W-1:0] ra, rb;
    logic         rc;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", {{W{1'b0}}, in_ready}, 17'd1);
        check("rst_out_valid", {{W{1'b0}}, out_valid}, 17'd0);
        check("rst_sum", {1'b0, sum}, 17'h0);
        check("rst_cout", {{W{1'b0}}, cout}, 17'd0);
        rst = 1'b0;

        // 1: full carry ripple, latency
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        check("t1_latency", 17'(lat), 17'(NNIB));
        check("t1_sum", {1'b0, sum}, 17'h0000);
        check("t1_cout", {{W{1'b0}}, cout}, 17'd1);
`ifdef OVERFLOW_FLAG_EN
        check("t1_ovf", {{W{1'b0}}, ovf}, 17'd0);
`endif
        pop();
        check("t1_back_idle", {{W{1'b0}}, in_ready}, 17'd1);

        // 2: carry-in
        send(16'h1234, 16'h4321, 1'b1);
        wait_done(lat);
        check("t2_sum", {1'b0, sum}, 17'h5556);
        check("t2_cout", {{W{1'b0}}, cout}, 17'd0);
        check("t2_in_ready_done", {{W{1'b0}}, in_ready}, 17'd0);
        pop();

        // 3: backpressure
        send(16'h8000, 16'h8000, 1'b1);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_sum", {1'b0, sum}, 17'h0001);
            check("t3_hold_cout", {{W{1'b0}}, cout}, 17'd1);
            check("t3_hold_in_ready", {{W{1'b0}}, in_ready}, 17'd0);
            @(negedge clk);
        end
        pop();
        check("t3_release_in_ready", {{W{1'b0}}, in_ready}, 17'd1);
        check("t3_release_out_valid", {{W{1'b0}}, out_valid}, 17'd0);

        // 4: reset mid-RUN
        send(16'hABCD, 16'h1111, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_out_valid", {{W{1'b0}}, out_valid}, 17'd0);
        check("t4_sum", {1'b0, sum}, 17'h0);
        check("t4_in_ready", {{W{1'b0}}, in_ready}, 17'd1);
        repeat (6) @(negedge clk);

        // 5: in_valid during RUN is ignored
        send(16'h0F0F, 16'h00F1, 1'b0);
        in_valid = 1'b1;
        a        = 16'h7777;
        b        = 16'h9999;
        cin      = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        wait_done(lat);
        check("t5_sum", {1'b0, sum}, 17'h1000);
        check("t5_cout", {{W{1'b0}}, cout}, 17'd0);
        pop();

`ifdef OVERFLOW_FLAG_EN
        // 6: signed overflow
        send(16'h7FFF, 16'h0001, 1'b0);
        wait_done(lat);
        check("t6_sum", {1'b0, sum}, 17'h8000);
        check("t6_ovf", {{W{1'b0}}, ovf}, 17'd1);
        check("t6_cout", {{W{1'b0}}, cout}, 17'd0);
        pop();
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_done(lat);
        check("t6b_ovf", {{W{1'b0}}, ovf}, 17'd0);
        pop();
`endif

        // random vectors
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom());
            rb = W'($urandom());
            rc = 1'($urandom_range(0, 1));
            exp_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            send(ra, rb, rc);
            wait_done(lat);
            check("rand_result", {cout, sum}, exp_full);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pop();
        end

        repeat (3) @(negedge clk);
        check("result_count", 17'(dut_results), 17'(m_results));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
